// File: rtl/flag_cond_unit_if.sv
// flag_cond_unit_if: ALU retire, instruction condition-check and result bundle for flag_cond_unit.
interface flag_cond_unit_if #(parameter int CNT_W = 16);
    logic             alu_valid;
    logic [3:0]       alu_op;
    logic             alu_s;
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;
    logic             ins_valid;
    logic [3:0]       ins_cond;
    logic             flush;
    logic [3:0]       nzcv;
    logic             exec_en;
    logic             squash;
    logic [CNT_W-1:0] squash_cnt;
    modport master (
        output alu_valid, alu_op, alu_s, alu_n, alu_z, alu_c, alu_v,
        output ins_valid, ins_cond, flush,
        input  nzcv, exec_en, squash, squash_cnt
    );
    modport slave (
        input  alu_valid, alu_op, alu_s, alu_n, alu_z, alu_c, alu_v,
        input  ins_valid, ins_cond, flush,
        output nzcv, exec_en, squash, squash_cnt
    );
endinterface

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: NZCV flag register with same-cycle bypass, ARM condition check and saturating squash counter.
module flag_cond_unit #(
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             reset,
    flag_cond_unit_if.slave bus
);
    logic             arith;
    logic             logical;
    logic             wr;
    logic [3:0]       nxt;
    logic             base;
    logic             pass;
    logic             fail;
    logic [3:0]       nzcv_r;
    logic             exec_r;
    logic             squash_r;
    logic [CNT_W-1:0] cnt;
    always_comb begin
        arith   = bus.alu_op inside {4'b0100, 4'b0010, 4'b1010};
        logical = bus.alu_op inside {4'b1000, 4'b1001, 4'b1110, 4'b1100, 4'b0001, 4'b1101, 4'b1111};
        wr      = bus.alu_valid & (bus.alu_s | (bus.alu_op inside {4'b1010, 4'b1000, 4'b1001}));
        nxt     = !wr    ? nzcv_r :
                  arith  ? {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} :
                  logical ? {bus.alu_n, bus.alu_z, nzcv_r[1:0]} : nzcv_r;
        // odd condition codes are the complement of the even one below them, AL/NV included
        base = 1'b0;
        case (bus.ins_cond[3:1])
            3'b000: base = nxt[2];
            3'b001: base = nxt[1];
            3'b010: base = nxt[3];
            3'b011: base = nxt[0];
            3'b100: base = nxt[1] & ~nxt[2];
            3'b101: base = nxt[3] == nxt[0];
            3'b110: base = ~nxt[2] & (nxt[3] == nxt[0]);
            default: base = 1'b1;
        endcase
        pass = base ^ bus.ins_cond[0];
        fail = bus.ins_valid & ~pass & ~bus.flush;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv_r   <= '0;
            exec_r   <= 1'b0;
            squash_r <= 1'b0;
            cnt      <= '0;
        end else begin
            nzcv_r   <= nxt;
            exec_r   <= bus.ins_valid & pass & ~bus.flush;
            squash_r <= fail;
            if (fail && !(&cnt)) cnt <= cnt + CNT_W'(1);
        end
    end
    assign bus.nzcv       = nzcv_r;
    assign bus.exec_en    = exec_r;
    assign bus.squash     = squash_r;
    assign bus.squash_cnt = cnt;
endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: directed vectors with hand-computed expectations for flag_cond_unit.
module tb_flag_cond_unit;
    localparam int CNT_W = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    flag_cond_unit_if #(.CNT_W(CNT_W)) bus ();
    flag_cond_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic alu(input logic v, input logic [3:0] op, input logic s, input logic [3:0] f);
        bus.alu_valid = v;
        bus.alu_op    = op;
        bus.alu_s     = s;
        {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = f;
    endtask
    task automatic ins(input logic v, input logic [3:0] c, input logic fl);
        bus.ins_valid = v;
        bus.ins_cond  = c;
        bus.flush     = fl;
    endtask
    task automatic outs(input string tag, input logic [3:0] f, input logic ex, input logic sq, input int c);
        chk({tag, ".nzcv"}, 32'(bus.nzcv), 32'(f));
        chk({tag, ".exec"}, 32'(bus.exec_en), 32'(ex));
        chk({tag, ".squash"}, 32'(bus.squash), 32'(sq));
        chk({tag, ".cnt"}, 32'(bus.squash_cnt), 32'(c));
    endtask
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    initial begin
        alu(0, 4'h0, 0, 4'h0);
        ins(0, 4'h0, 0);
        #3;
        outs("reset", 4'h0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        ins(1, 4'h0, 0);
        step();
        outs("first_eq", 4'h0, 0, 1, 1);
        alu(1, 4'b1010, 0, 4'b0100);
        ins(1, 4'h0, 0);
        step();
        outs("bypass_cmp", 4'b0100, 1, 0, 1);
        alu(0, 4'h0, 0, 4'h0);
        ins(0, 4'h0, 0);
        step();
        outs("idle", 4'b0100, 0, 0, 1);
        alu(1, 4'b0010, 1, 4'b0011);
        step();
        chk("sub_s", 32'(bus.nzcv), 32'h3);
        alu(1, 4'b1100, 1, 4'b1000);
        step();
        chk("orr_keep_cv", 32'(bus.nzcv), 32'hB);
        alu(1, 4'b0100, 0, 4'b0100);
        step();
        chk("add_no_s", 32'(bus.nzcv), 32'hB);
        alu(1, 4'b0000, 1, 4'b0100);
        step();
        chk("and_op_ignored", 32'(bus.nzcv), 32'hB);
        alu(1, 4'b1000, 0, 4'b0100);
        step();
        chk("tst_no_s", 32'(bus.nzcv), 32'h7);
        alu(0, 4'b1000, 1, 4'b1111);
        step();
        chk("alu_invalid", 32'(bus.nzcv), 32'h7);
        for (int f = 0; f < 16; f++) begin
            alu(1, 4'b0100, 1, 4'(f));
            ins(0, 4'h0, 0);
            step();
            alu(0, 4'h0, 0, 4'h0);
            for (int c = 0; c < 16; c++) begin
                ins(1, 4'(c), 0);
                step();
                chk($sformatf("sweep_exec f=%0h c=%0h", f, c), 32'(bus.exec_en), 32'(cond_ref(4'(c), 4'(f))));
                chk($sformatf("sweep_sq f=%0h c=%0h", f, c), 32'(bus.squash), 32'(!cond_ref(4'(c), 4'(f))));
            end
        end
        ins(0, 4'h0, 0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        outs("reset2", 4'h0, 0, 0, 0);
        alu(1, 4'b0100, 1, 4'b1010);
        ins(1, 4'hF, 1);
        step();
        outs("flush", 4'b1010, 0, 0, 0);
        alu(0, 4'h0, 0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            ins(1, 4'hF, 0);
            step();
            chk($sformatf("sat_cnt %0d", i), 32'(bus.squash_cnt), 32'((i + 1 > 15) ? 15 : i + 1));
            chk($sformatf("sat_sq %0d", i), 32'(bus.squash), 32'd1);
        end
        ins(1, 4'hF, 1);
        step();
        outs("flush_sat", 4'b1010, 0, 0, 15);
        ins(1, 4'hE, 0);
        step();
        chk("pre_async_exec", 32'(bus.exec_en), 32'd1);
        alu(1, 4'b0100, 1, 4'b1111);
        #3;
        reset = 1'b1;
        #1;
        outs("async_reset", 4'h0, 0, 0, 0);
        step();
        outs("reset_held", 4'h0, 0, 0, 0);
        @(negedge clk);
        alu(0, 4'h0, 0, 4'h0);
        ins(0, 4'h0, 0);
        reset = 1'b0;
        step();
        outs("post_release", 4'h0, 0, 0, 0);
        ins(1, 4'hC, 0);
        step();
        outs("gt_zero_flags", 4'h0, 1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
